// File: rtl/result_bcd_formatter_pkg.sv
// Shared constants and state encoding for the result-to-BCD formatter.
package result_bcd_formatter_pkg;

  localparam int          BCD_DIGITS  = 4;
  localparam int          ACC_W       = 4 * BCD_DIGITS;
  localparam logic [3:0]  DIGIT_BLANK = 4'hF;
  localparam logic [13:0] MAX_DISPLAY = 14'd9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/result_bcd_formatter_bcd_add3.sv
// Double-dabble nibble correction: adds 3 to any BCD nibble of 5 or more.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] corrected
);

  assign corrected = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/result_bcd_formatter.sv
// Sequential binary-to-BCD converter feeding the 4-digit display driver, with
// optional leading-zero blanking, overflow indication and a one-entry request buffer.
module result_bcd_formatter
  import result_bcd_formatter_pkg::*;
#(
  parameter int IN_W     = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_value,
  input  logic            in_valid,
  output logic            busy,
  output logic [3:0]      num1,
  output logic [3:0]      num2,
  output logic [3:0]      num3,
  output logic [3:0]      num4,
  output logic            out_valid,
  output logic            ovf
);

  localparam int         CNT_W  = $clog2(IN_W + 1);
  localparam logic [3:0] RST_HI = BLANK_LZ ? DIGIT_BLANK : 4'd0;

  state_t                          state_r;
  state_t                          state_next_s;
  logic [IN_W-1:0]                 shreg_r;
  logic [ACC_W-1:0]                acc_r;
  logic [ACC_W-1:0]                acc_adj_s;
  logic [ACC_W+IN_W-1:0]           shifted_s;
  logic [CNT_W-1:0]                cnt_r;
  logic                            ovf_cmp_r;
  logic                            pend_full_r;
  logic [IN_W-1:0]                 pend_value_r;
  logic                            start_s;
  logic [IN_W-1:0]                 start_value_s;
  logic                            load_s;
  logic                            busy_next_s;
  logic [BCD_DIGITS-1:0][3:0]      fmt_s;
  logic [BCD_DIGITS-1:0][3:0]      num_r;
  logic                            busy_r;
  logic                            out_valid_r;
  logic                            ovf_r;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble    (acc_r[4*g +: 4]),
      .corrected (acc_adj_s[4*g +: 4])
    );
  end

  assign shifted_s = {acc_adj_s, shreg_r} << 1;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and conversion start; a request on the LOAD cycle beats the pending slot
  always_comb begin
    state_next_s  = state_r;
    start_s       = 1'b0;
    start_value_s = in_value;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          start_s      = 1'b1;
          state_next_s = CONV;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONV: begin
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = CONV;
        end
      end
      LOAD: begin
        if (in_valid) begin
          start_s      = 1'b1;
          state_next_s = CONV;
        end else if (pend_full_r) begin
          start_s       = 1'b1;
          start_value_s = pend_value_r;
          state_next_s  = CONV;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode: digit formatting with overflow and leading-zero blanking
  always_comb begin
    load_s      = (state_r == LOAD);
    busy_next_s = (state_next_s != IDLE);
    fmt_s       = acc_r;
    if (ovf_cmp_r) begin
      fmt_s = {BCD_DIGITS{DIGIT_BLANK}};
    end else if (BLANK_LZ) begin
      if (acc_r[15:12] == 4'd0) fmt_s[3] = DIGIT_BLANK; else fmt_s[3] = acc_r[15:12];
      if (acc_r[15:8] == 8'd0)  fmt_s[2] = DIGIT_BLANK; else fmt_s[2] = acc_r[11:8];
      if (acc_r[15:4] == 12'd0) fmt_s[1] = DIGIT_BLANK; else fmt_s[1] = acc_r[7:4];
    end else begin
      fmt_s = acc_r;
    end
  end

  // Shift register, BCD accumulator, shift count and latched overflow compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r   <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      ovf_cmp_r <= 1'b0;
    end else if (start_s) begin
      shreg_r   <= start_value_s;
      acc_r     <= '0;
      cnt_r     <= CNT_W'(IN_W);
      ovf_cmp_r <= (14'(start_value_s) > MAX_DISPLAY);
    end else if (state_r == CONV) begin
      {acc_r, shreg_r} <= shifted_s;
      cnt_r            <= cnt_r - CNT_W'(1);
    end else begin
      shreg_r   <= shreg_r;
      acc_r     <= acc_r;
      cnt_r     <= cnt_r;
      ovf_cmp_r <= ovf_cmp_r;
    end
  end

  // One-entry pending slot: last request while converting wins, drained at LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_r  <= 1'b0;
      pend_value_r <= '0;
    end else if (state_r == LOAD) begin
      pend_full_r  <= 1'b0;
      pend_value_r <= pend_value_r;
    end else if ((state_r == CONV) && in_valid) begin
      pend_full_r  <= 1'b1;
      pend_value_r <= in_value;
    end else begin
      pend_full_r  <= pend_full_r;
      pend_value_r <= pend_value_r;
    end
  end

  // Registered outputs; digits and ovf only move at LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_r       <= {RST_HI, RST_HI, RST_HI, 4'd0};
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      busy_r      <= busy_next_s;
      out_valid_r <= load_s;
      if (load_s) begin
        num_r <= fmt_s;
        ovf_r <= ovf_cmp_r;
      end else begin
        num_r <= num_r;
        ovf_r <= ovf_r;
      end
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign ovf       = ovf_r;
  assign num1      = num_r[0];
  assign num2      = num_r[1];
  assign num3      = num_r[2];
  assign num4      = num_r[3];

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Self-checking bench for result_bcd_formatter: blanking and non-blanking instances
// driven in parallel and compared against an arithmetic decimal model.
module tb_result_bcd_formatter;

  localparam int IN_W = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [IN_W-1:0] in_value = '0;
  logic            in_valid = 1'b0;

  logic       busy_a, ov_a, ovf_a, busy_b, ov_b, ovf_b;
  logic [3:0] n1_a, n2_a, n3_a, n4_a, n1_b, n2_b, n3_b, n4_b;
  logic [15:0] dig_a, dig_b;

  int vectors = 0;
  int miscompares = 0;

  assign dig_a = {n4_a, n3_a, n2_a, n1_a};
  assign dig_b = {n4_b, n3_b, n2_b, n1_b};

  always #5 clk = ~clk;

  result_bcd_formatter #(.IN_W(IN_W), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_valid(in_valid),
    .busy(busy_a), .num1(n1_a), .num2(n2_a), .num3(n3_a), .num4(n4_a),
    .out_valid(ov_a), .ovf(ovf_a)
  );

  result_bcd_formatter #(.IN_W(IN_W), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_valid(in_valid),
    .busy(busy_b), .num1(n1_b), .num2(n2_b), .num3(n3_b), .num4(n4_b),
    .out_valid(ov_b), .ovf(ovf_b)
  );

  // Decimal display model: {num4,num3,num2,num1}
  function automatic logic [15:0] ref_digits(input int v, input bit blank);
    logic [15:0] r;
    if (v > 9999) return 16'hFFFF;
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    if (blank && v < 1000) r[15:12] = 4'hF;
    if (blank && v < 100)  r[11:8]  = 4'hF;
    if (blank && v < 10)   r[7:4]   = 4'hF;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input int v, input string tag);
    int cyc;
    int bcyc;
    cyc  = 0;
    bcyc = 0;
    @(negedge clk);
    in_value = IN_W'(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < 40 && !ov_a) begin
      if (busy_a) bcyc++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, IN_W + 1);
    check({tag, "_busy_cycles"}, bcyc, IN_W + 1);
    check({tag, "_digits_blank"}, dig_a, ref_digits(v, 1'b1));
    check({tag, "_digits_plain"}, dig_b, ref_digits(v, 1'b0));
    check({tag, "_ovf"}, ovf_a, (v > 9999));
    check({tag, "_ovf_plain"}, ovf_b, (v > 9999));
    check({tag, "_valid_plain"}, ov_b, 1);
    check({tag, "_busy_done"}, busy_a, 0);
    @(negedge clk);
    check({tag, "_single_pulse"}, ov_a, 0);
  endtask

  // Accept v0, then one-cycle requests v1 at cycle c1 and v2 at cycle c2 after accept
  task automatic two_req(input int v0, input int c1, input int v1, input int c2, input int v2,
                         input string tag);
    int pulses;
    logic [15:0] rec0, rec1;
    logic busy_at_first;
    pulses = 0;
    rec0 = '0;
    rec1 = '0;
    busy_at_first = 1'b0;
    @(negedge clk);
    in_value = IN_W'(v0);
    in_valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      if (ov_a) begin
        if (pulses == 0) begin
          rec0 = dig_a;
          busy_at_first = busy_a;
        end else if (pulses == 1) begin
          rec1 = dig_a;
        end else begin
          rec1 = rec1;
        end
        pulses++;
      end
      in_valid = (c == c1) || (c == c2);
      in_value = IN_W'((c == c2) ? v2 : v1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, "_pulses"}, pulses, 2);
    check({tag, "_first"}, rec0, ref_digits(v0, 1'b1));
    check({tag, "_second"}, rec1, ref_digits(v2, 1'b1));
    check({tag, "_busy_between"}, busy_at_first, 1);
  endtask

  initial begin
    int v;
    int changes;
    int pulses;
    logic [15:0] snap_a, snap_b;
    int directed[10] = '{1234, 7, 0, 1005, 9999, 10000, 16383, 10, 100, 1000};

    #1 rst_n = 1'b0;
    #1;
    check("reset_digits_blank", dig_a, 16'hFFF0);
    check("reset_digits_plain", dig_b, 16'h0000);
    check("reset_busy", busy_a, 0);
    check("reset_valid", ov_a, 0);
    check("reset_ovf", ovf_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (directed[i]) convert(directed[i], $sformatf("dir%0d", directed[i]));

    for (int i = 0; i < 16; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 120));
      convert(v, $sformatf("rnd%0d", v));
    end

    two_req(42, 2, 58, 5, 63, "pend");
    two_req(500, 3, 11, 14, 77, "load_overwrite");

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    in_value = IN_W'(1234);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_digits_blank", dig_a, 16'hFFF0);
    check("midrst_digits_plain", dig_b, 16'h0000);
    check("midrst_busy", busy_a, 0);
    check("midrst_valid", ov_a, 0);
    check("midrst_ovf", ovf_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (ov_a || busy_a) pulses++;
      @(negedge clk);
    end
    check("midrst_no_activity", pulses, 0);
    convert(88, "after_rst");

    // Digits held with no requests
    snap_a = dig_a;
    snap_b = dig_b;
    changes = 0;
    pulses = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (dig_a != snap_a || dig_b != snap_b) changes++;
      if (ov_a) pulses++;
    end
    check("hold_changes", changes, 0);
    check("hold_pulses", pulses, 0);
    check("hold_value", dig_a, ref_digits(88, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
